sram_frame_reader: RTL

Read-side engine for the 32-bit packed framebuffer SRAM. On a start pulse it walks word addresses 0 to NUM_WORDS-1 through the SRAM's synchronous read port (1-cycle latency), unpacks each 32-bit word into four 8-bit pixels, and streams them out on a valid/ready byte interface toward the UART transmit path. It is the consumer counterpart of the FIFO-to-SRAM writer.

---
 rtl/sram_frame_reader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sram_frame_reader.sv
// sram_frame_reader: reads one frame out of a 32-bit packed framebuffer
// SRAM (synchronous read, 1-cycle latency) and streams it as bytes over a
// valid/ready interface. Four pixels per word, one SRAM read per word.
// Optional build macro SRAM_FRAME_READER_MSB_FIRST_EN: when defined, each
// word is emitted most-significant byte first; otherwise least-significant
// byte first. Timing is identical in both builds.
module sram_frame_reader #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Terminal word index; all-ones when NUM_WORDS == 2^ADDR_W, so the
  // counter never has to hold NUM_WORDS itself.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORD_INC  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] WORD_ZERO = {ADDR_W{1'b0}};

  // Selects the byte emitted for a given position within the word.
  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] word,
                                           input logic [1:0]        idx);
    logic [7:0] b;
    case (idx)
`ifdef SRAM_FRAME_READER_MSB_FIRST_EN
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
`else
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] word_cnt_r;
  logic [1:0]        byte_idx_r;
  logic [DATA_W-1:0] word_r;

  logic [2:0]        state_s;
  logic [ADDR_W-1:0] word_cnt_s;
  logic [1:0]        byte_idx_s;
  logic [DATA_W-1:0] word_s;
  logic              handshake_s;

  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              m_valid_s;
  logic [7:0]        m_data_s;
  logic              m_last_s;
  logic              busy_s;
  logic              done_s;

  // m_valid is registered and high exactly in SEND, so this is the handshake.
  assign handshake_s = m_valid & m_ready;

  // Next-state and counter update for the readout sequencer.
  always_comb begin
    state_s    = state_r;
    word_cnt_s = word_cnt_r;
    byte_idx_s = byte_idx_r;
    word_s     = word_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_FETCH;
          word_cnt_s = WORD_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // SRAM data for the address issued in FETCH is valid now.
        word_s     = rd_data;
        byte_idx_s = 2'd0;
        state_s    = ST_SEND;
      end
      ST_SEND: begin
        if (handshake_s) begin
          if (byte_idx_r != 2'd3) begin
            byte_idx_s = byte_idx_r + 2'd1;
          end else if (word_cnt_r != LAST_WORD) begin
            word_cnt_s = word_cnt_r + WORD_INC;
            state_s    = ST_FETCH;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so every output is a flop.
  always_comb begin
    rd_en_s   = (state_s == ST_FETCH);
    rd_addr_s = WORD_ZERO;
    m_valid_s = (state_s == ST_SEND);
    m_data_s  = 8'h00;
    m_last_s  = 1'b0;
    busy_s    = (state_s == ST_FETCH) || (state_s == ST_WAIT) || (state_s == ST_SEND);
    done_s    = (state_s == ST_DONE);
    if (state_s == ST_FETCH) begin
      rd_addr_s = word_cnt_s;
    end else begin
      rd_addr_s = WORD_ZERO;
    end
    if (state_s == ST_SEND) begin
      m_data_s = pick_byte(word_s, byte_idx_s);
      m_last_s = (byte_idx_s == 2'd3) && (word_cnt_s == LAST_WORD);
    end else begin
      m_data_s = 8'h00;
      m_last_s = 1'b0;
    end
  end

  // State, counters, word buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      word_cnt_r <= WORD_ZERO;
      byte_idx_r <= 2'd0;
      word_r     <= {DATA_W{1'b0}};
      rd_en      <= 1'b0;
      rd_addr    <= WORD_ZERO;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_cnt_r <= word_cnt_s;
      byte_idx_r <= byte_idx_s;
      word_r     <= word_s;
      rd_en      <= rd_en_s;
      rd_addr    <= rd_addr_s;
      m_valid    <= m_valid_s;
      m_data     <= m_data_s;
      m_last     <= m_last_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

endmodule
